alu_seq: RTL and testbench

Multi-cycle execution unit that consumes the 6-bit ALU function code produced by the ALU control decoder and performs the operation on two 32-bit operands. It sits in the execute stage, downstream of the ALU control logic. Each operation is accepted through a start/busy/done handshake. ADDU and SUBU complete immediately; SLL and SLLV run one bit position per cycle under a small state machine.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 110 +++++++++++
 tb/tb_alu_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done operation bus between the execute-stage issuer and alu_seq.
// Latency: none, wires only.
// Backpressure: the issuer must not expect a request to be taken while busy is high.
// Ports: start, funct, src1, src2, shamt (issuer to unit); result, carry, busy, done (unit to issuer).
interface alu_seq_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        carry;
    logic        busy;
    logic        done;

    modport master (
        output start, funct, src1, src2, shamt,
        input  result, carry, busy, done
    );

    modport slave (
        input  start, funct, src1, src2, shamt,
        output result, carry, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ADDU/SUBU/SLL/SLLV execution unit for the execute stage.
// Latency: 1 cycle for ADDU, SUBU, unknown funct and zero shifts; k+1 cycles for a shift by k (max 32).
// Backpressure: busy is high during a shift; start is ignored (not queued) while busy.
// Ports: clk, rst (sync active-high); io (slave side of alu_seq_if) carries the operation and result.
module alu_seq (
    input  logic         clk,
    input  logic         rst,
    alu_seq_if.slave     io
);

    localparam logic [5:0] F_ADDU = 6'b001001;
    localparam logic [5:0] F_SUBU = 6'b001010;
    localparam logic [5:0] F_SLL  = 6'b100001;
    localparam logic [5:0] F_SLLV = 6'b110101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        done_q, done_d;
    logic [4:0]  amt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            work_q   <= 32'd0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        amt      = (io.funct == F_SLL) ? io.shamt : io.src1[4:0];

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    case (io.funct)
                        F_ADDU: begin
                            {carry_d, result_d} = {1'b0, io.src1} + {1'b0, io.src2};
                            done_d = 1'b1;
                        end
                        F_SUBU: begin
                            result_d = io.src1 - io.src2;
                            carry_d  = (io.src1 < io.src2);
                            done_d   = 1'b1;
                        end
                        F_SLL, F_SLLV: begin
                            if (amt == 5'd0) begin
                                // Zero shift completes like an ALU op, no SHIFT visit.
                                result_d = io.src2;
                                carry_d  = 1'b0;
                                done_d   = 1'b1;
                            end else begin
                                state_d = SHIFT;
                                cnt_d   = amt;
                                work_d  = io.src2;
                            end
                        end
                        default: begin
                            result_d = 32'd0;
                            carry_d  = 1'b0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_d = work_q << 1;
                cnt_d  = cnt_q - 5'd1;
                // Last step: publish the final shifted value directly so result
                // lands in the same cycle busy drops.
                if (cnt_q == 5'd1) begin
                    result_d = work_q << 1;
                    carry_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.result = result_q;
    assign io.carry  = carry_q;
    assign io.busy   = (state_q == SHIFT);
    assign io.done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with directed cases and randomized ops.
// Latency: expected latency per op comes from the reference model (1, or k+1 for shifts).
// Backpressure: waits on done are bounded; an expired bound shows up as failed checks.
module tb_alu_seq;

    localparam logic [5:0] F_ADDU = 6'b001001;
    localparam logic [5:0] F_SUBU = 6'b001010;
    localparam logic [5:0] F_SLL  = 6'b100001;
    localparam logic [5:0] F_SLLV = 6'b110101;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    alu_seq_if bus ();

    alu_seq u_dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Reference: what the op means arithmetically and how long it should take.
    task automatic model(input logic [5:0] f, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] sh, output logic [31:0] res, output logic cy,
                         output int lat);
        longint unsigned sum;
        int k;
        res = 32'd0; cy = 1'b0; lat = 1;
        case (f)
            F_ADDU: begin
                sum = longint'(s1) + longint'(s2);
                res = s1 + s2;
                cy  = (sum > 64'hFFFF_FFFF);
            end
            F_SUBU: begin
                res = s1 - s2;
                cy  = (s1 < s2);
            end
            F_SLL, F_SLLV: begin
                k   = (f == F_SLL) ? int'(sh) : int'(s1 % 32);
                res = s2 << k;
                lat = k + 1;
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] sh, input bit poke);
        logic [31:0] er;
        logic        ec;
        int          el;
        int          cyc;
        model(f, s1, s2, sh, er, ec, el);
        @(negedge clk);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.funct = f; bus.src1 = s1; bus.src2 = s2; bus.shamt = sh; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble operands: the unit must have sampled them at accept.
        bus.src1 = $urandom; bus.src2 = $urandom; bus.shamt = 5'($urandom);
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            check("busy_high", 32'(bus.busy), 32'd1);
            if (poke && cyc == 2) begin
                bus.start = 1'b1;
                bus.funct = F_ADDU;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("done", 32'(bus.done), 32'd1);
        check("latency", 32'(cyc), 32'(el));
        check("result", bus.result, er);
        check("carry", 32'(bus.carry), 32'(ec));
        check("busy_at_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [5:0] rf;
        n_checks = 0;
        n_pass   = 0;

        // Reset held with a pending ADDU request: nothing may be accepted.
        rst = 1'b1;
        bus.start = 1'b1; bus.funct = F_ADDU;
        bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'h2; bus.shamt = 5'd0;
        repeat (2) begin
            @(negedge clk);
            check("rst_result", bus.result, 32'd0);
            check("rst_carry", 32'(bus.carry), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(bus.done), 32'd0);

        run_op(F_ADDU, 32'hFFFF_FFFF, 32'h2, 5'd0, 1'b0);
        check("addu_lit", bus.result, 32'h1);
        run_op(F_SUBU, 32'd5, 32'd7, 5'd0, 1'b0);
        check("subu_lit", bus.result, 32'hFFFF_FFFE);
        run_op(F_SLL, 32'd0, 32'h3, 5'd4, 1'b1);
        check("sll_lit", bus.result, 32'h30);
        run_op(F_SLLV, 32'hFFFF_FFE0, 32'h1234_5678, 5'd9, 1'b0);
        run_op(F_SLLV, 32'd31, 32'd1, 5'd0, 1'b0);
        check("sllv31_lit", bus.result, 32'h8000_0000);

        // Back-to-back: SLL issued in the done cycle of an ADDU.
        @(negedge clk);
        bus.funct = F_ADDU; bus.src1 = 32'd3; bus.src2 = 32'd4; bus.start = 1'b1;
        @(negedge clk);
        check("b2b_addu_done", 32'(bus.done), 32'd1);
        check("b2b_addu_res", bus.result, 32'd7);
        bus.funct = F_SLL; bus.src2 = 32'd1; bus.shamt = 5'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_nodone", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("b2b_done", 32'(bus.done), 32'd1);
        check("b2b_res", bus.result, 32'd2);

        run_op(6'b111111, 32'hDEAD_BEEF, 32'h1234, 5'd3, 1'b0);
        check("unk_lit", bus.result, 32'd0);

        // Reset in the third busy cycle of SLL by 10.
        @(negedge clk);
        bus.funct = F_SLL; bus.src2 = 32'h5; bus.shamt = 5'd10; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy3", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("mid_no_done", 32'(bus.done), 32'd0);
        end
        run_op(F_ADDU, 32'd1, 32'd1, 5'd0, 1'b0);
        check("after_rst_addu", bus.result, 32'd2);

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: rf = F_ADDU;
                1: rf = F_SUBU;
                2: rf = F_SLL;
                3: rf = F_SLLV;
                default: rf = 6'($urandom);
            endcase
            run_op(rf, $urandom, $urandom, 5'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
